// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
package y86_mem_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned QUAD_BYTES = 8;

  // Y86-64 status codes; ADR is what the memory stage reports for rsp_error.
  localparam logic [3:0] AOK = 4'd1;
  localparam logic [3:0] HLT = 4'd2;
  localparam logic [3:0] ADR = 4'd3;
  localparam logic [3:0] INS = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmemReq_t;

  // 65-bit end-address compare so addresses near 2^64 cannot wrap into range.
  function automatic logic quadOutOfRange(input logic [XLEN-1:0] addr,
                                          input int unsigned     memBytes);
    return ({1'b0, addr} + 65'(QUAD_BYTES)) > 65'(memBytes);
  endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-addressed storage with one little-endian 8-byte read port and write port.
module y86_byte_ram
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Lowest address supplies the least significant byte.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < QUAD_BYTES; i++) begin
      rdata[8*i +: 8] = mem[addr + ADDR_BITS'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < QUAD_BYTES; i++) begin
        mem[addr + ADDR_BITS'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder: one quad load/store per handshake after LATENCY wait cycles.
// Optional DMEM_ALIGN_CHECK_EN: flag addresses with addr[2:0] != 0 as address errors.
module y86_dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned ADDR_BITS = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CNT_BITS  = 4;
  localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam bit ZERO_LATENCY = (LATENCY == 0);

  dmemState_t            state;
  dmemReq_t              pending;
  logic [CNT_BITS-1:0]   waitCnt;

  dmemReq_t              access;
  logic                  accessNow;
  logic                  accessErr;
  logic                  ramWe;
  logic [XLEN-1:0]       ramRdata;
  logic [XLEN-1:0]       accessRdata;

  // With zero latency the access happens on the accepting edge, straight from the request.
  always_comb begin
    access = pending;
    if (state == IDLE) begin
      access = {req_write, req_addr, req_wdata};
    end
  end

  always_comb begin
    accessNow = (state == WAIT) && (waitCnt == '0);
    if (ZERO_LATENCY && (state == IDLE) && req_valid && req_ready) begin
      accessNow = 1'b1;
    end
    accessErr = quadOutOfRange(access.addr, MEM_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
    if (access.addr[2:0] != 3'd0) begin
      accessErr = 1'b1;
    end
`endif
    ramWe       = accessNow && access.write && !accessErr;
    accessRdata = (access.write || accessErr) ? '0 : ramRdata;
  end

  y86_byte_ram #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ramWe),
    .addr (access.addr[ADDR_BITS-1:0]),
    .wdata(access.wdata),
    .rdata(ramRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      waitCnt   <= '0;
      pending   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            pending   <= access;
            req_ready <= 1'b0;
            if (ZERO_LATENCY) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= accessRdata;
              rsp_error <= accessErr;
            end else begin
              state   <= WAIT;
              waitCnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= accessRdata;
            rsp_error <= accessErr;
          end else begin
            waitCnt <= waitCnt - CNT_BITS'(1);
          end
        end
        RESP: begin
          // Response data stays frozen until the requester takes it.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Self-checking bench for y86_dmem_responder: vector table, corner sequences, random vs byte-array model.
module tb_y86_dmem_responder;

  localparam int MEMB = 1024;
  localparam int LAT  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [MEMB];

  typedef struct {
    string       tag;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  y86_dmem_responder #(
    .MEM_BYTES(MEMB),
    .LATENCY  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rule: the quad must fit inside the array (and be aligned when the check is on).
  function automatic logic modelErr(input logic [63:0] a);
    logic [64:0] lastPlusOne;
    logic        e;
    lastPlusOne = {1'b0, a} + 65'd8;
    e = lastPlusOne > 65'(MEMB);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[2:0] != 3'd0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic modelAccess(input logic w, input logic [63:0] a, input logic [63:0] d,
                             output logic [63:0] rd, output logic er);
    int base;
    er = modelErr(a);
    rd = '0;
    base = int'(a[31:0]);
    if (!er) begin
      for (int i = 0; i < 8; i++) begin
        if (w) model[base + i] = d[8*i +: 8];
        else   rd[8*i +: 8] = model[base + i];
      end
    end
  endtask

  task automatic issue(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check1({tag, "_accept_ready"}, req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int lat, output logic readyLow);
    lat = 0;
    readyLow = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) readyLow = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (req_ready) readyLow = 1'b0;
  endtask

  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check1({tag, "_ack_valid_low"}, rsp_valid, 1'b0);
    check1({tag, "_ack_ready_high"}, req_ready, 1'b1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] expRd, input logic expEr, input int ackDelay);
    int   lat;
    logic rl;
    issue(tag, w, a, d);
    waitRsp(lat, rl);
    check1({tag, "_valid"}, rsp_valid, 1'b1);
    checkInt({tag, "_latency"}, lat, LAT);
    check1({tag, "_busy_not_ready"}, rl, 1'b1);
    check64({tag, "_rdata"}, rsp_rdata, expRd);
    check1({tag, "_error"}, rsp_error, expEr);
    for (int k = 0; k < ackDelay; k++) begin
      @(posedge clk); #1;
      check1({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check64({tag, "_hold_rdata"}, rsp_rdata, expRd);
    end
    ack(tag);
  endtask

  logic [63:0] mrd;
  logic        mer;
  logic [63:0] ra;
  logic [63:0] rdat;
  logic        rw;
  int          lat;
  logic        rl;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    #2;
    check1("reset_req_ready", req_ready, 1'b1);
    check1("reset_rsp_valid", rsp_valid, 1'b0);
    check64("reset_rsp_rdata", rsp_rdata, 64'h0);
    check1("reset_rsp_error", rsp_error, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // rsp_ready high while idle must not fabricate a response.
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1("idle_ready_no_rsp", rsp_valid, 1'b0);
      check1("idle_ready_req_ready", req_ready, 1'b1);
    end
    rsp_ready = 1'b0;

    // Give every byte a known value so the model covers the whole array.
    for (int i = 0; i < MEMB / 8; i++) begin
      txn("zero_fill", 1'b1, 64'(i * 8), 64'h0, 64'h0, 1'b0, 0);
    end
    for (int i = 0; i < MEMB; i++) model[i] = 8'h00;

    vecs.push_back('{"st_100",    1'b1, 64'h100, 64'h1122334455667788, 64'h0, 1'b0});
    vecs.push_back('{"ld_100",    1'b0, 64'h100, 64'h0, 64'h1122334455667788, 1'b0});
    vecs.push_back('{"ld_3f9",    1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{"st_3f8",    1'b1, 64'h3F8, 64'hCAFEF00D12345678, 64'h0, 1'b0});
    vecs.push_back('{"st_3f9",    1'b1, 64'h3F9, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b1});
    vecs.push_back('{"ld_3f8",    1'b0, 64'h3F8, 64'h0, 64'hCAFEF00D12345678, 1'b0});
    vecs.push_back('{"ld_wrap_fc", 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{"ld_wrap_f8", 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{"ld_3f0",    1'b0, 64'h3F0, 64'h0, 64'h0, 1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back('{"ld_103_align", 1'b0, 64'h103, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{"st_101_align", 1'b1, 64'h101, 64'h5555555555555555, 64'h0, 1'b1});
    vecs.push_back('{"ld_100_intact", 1'b0, 64'h100, 64'h0, 64'h1122334455667788, 1'b0});
`else
    vecs.push_back('{"ld_103_endian", 1'b0, 64'h103, 64'h0, 64'h0000001122334455, 1'b0});
`endif

    foreach (vecs[i]) begin
      txn(vecs[i].tag, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].er, i % 3);
      modelAccess(vecs[i].w, vecs[i].a, vecs[i].d, mrd, mer);
    end

    // Stalled response: outputs frozen, a waiting request is held off until the handshake.
    issue("stall", 1'b0, 64'h100, 64'h0);
    waitRsp(lat, rl);
    check1("stall_valid", rsp_valid, 1'b1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h3F8;
    req_wdata = 64'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check1("stall_hold_valid", rsp_valid, 1'b1);
      check64("stall_hold_rdata", rsp_rdata, 64'h1122334455667788);
      check1("stall_hold_error", rsp_error, 1'b0);
      check1("stall_no_accept", req_ready, 1'b0);
    end
    ack("stall");
    issue("stall_next", 1'b0, 64'h3F8, 64'h0);
    waitRsp(lat, rl);
    check1("stall_next_valid", rsp_valid, 1'b1);
    checkInt("stall_next_latency", lat, LAT);
    check64("stall_next_rdata", rsp_rdata, 64'hCAFEF00D12345678);
    ack("stall_next");

    // Reset during the wait of a store: the store is dropped, outputs clear at once.
    txn("rst_prep_st", 1'b1, 64'h40, 64'h0123456789ABCDEF, 64'h0, 1'b0, 0);
    modelAccess(1'b1, 64'h40, 64'h0123456789ABCDEF, mrd, mer);
    txn("rst_prep_ld", 1'b0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 1'b0, 0);
    issue("rst_store", 1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA);
    rst = 1'b1;
    #1;
    check1("rst_mid_req_ready", req_ready, 1'b1);
    check1("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check64("rst_mid_rsp_rdata", rsp_rdata, 64'h0);
    check1("rst_mid_rsp_error", rsp_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1("rst_after_no_rsp", rsp_valid, 1'b0);
    end
    txn("rst_after_ld", 1'b0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    txn("ld_41_align", 1'b0, 64'h41, 64'h0, 64'h0, 1'b1, 0);
`endif

    // Random traffic against the byte-array model.
    for (int n = 0; n < 150; n++) begin
      rw   = 1'($urandom_range(0, 1));
      rdat = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0, 1, 2: ra = 64'($urandom_range(0, MEMB - 1));
        3:       ra = 64'(MEMB - 16 + int'($urandom_range(0, 15)));
        4:       ra = {$urandom, $urandom};
        5:       ra = 64'(8 * int'($urandom_range(0, MEMB / 8 - 1)));
        default: ra = 64'(256 + int'($urandom_range(0, 15)));
      endcase
      modelAccess(rw, ra, rdat, mrd, mer);
      txn("rand", rw, ra, rdat, mrd, mer, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
